// File: rtl/victim_cache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// victim_cache_ctrl_pkg
//   Shared types for the victim cache controller and its allocator.
//   The package fixes the default geometry (4 slots, 6-bit index, 20-bit tag,
//   16-word lines); the modules take the same values as parameter defaults and
//   must be built with matching values because the directory entry and line
//   types below are sized from these constants.
// -----------------------------------------------------------------------------
package victim_cache_ctrl_pkg;

    localparam int VC_SIZE          = 4;
    localparam int VC_INDEX_WIDTH   = 6;
    localparam int VC_TAG_WIDTH     = 20;
    localparam int VC_LINE_WORD_NUM = 16;
    localparam int VC_TI_WIDTH      = VC_TAG_WIDTH + VC_INDEX_WIDTH;

    typedef enum logic {
        VC_PROBE  = 1'b0,
        VC_INSERT = 1'b1
    } vc_op_e;

    // One directory entry: flop copy of a victim slot used for the
    // single-cycle associative search.
    typedef struct packed {
        logic                      valid;
        logic                      dirty;
        logic [VC_TAG_WIDTH-1:0]   tag;
        logic [VC_INDEX_WIDTH-1:0] index;
    } vc_dir_t;

    typedef logic [VC_LINE_WORD_NUM-1:0][31:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_P_RD   = 3'd1,
        ST_P_RESP = 3'd2,
        ST_I_RD   = 3'd3,
        ST_I_WB   = 3'd4,
        ST_I_WR   = 3'd5
    } vc_state_e;

    // {tag,index} of a directory entry, i.e. the line address it holds.
    function automatic logic [VC_TI_WIDTH-1:0] dir_tagindex(input vc_dir_t e);
        return {e.tag, e.index};
    endfunction

endpackage

// File: rtl/vc_alloc.sv
// -----------------------------------------------------------------------------
// vc_alloc
//   Slot search and allocation for the victim cache directory.
//   - Associative hit search of {tag,index} over all valid slots.
//   - Priority encoder returning the lowest-numbered invalid slot.
//   - Round-robin FIFO pointer used as the replacement victim when every slot
//     is valid; it advances (modulo SIZE) only when told to.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears pointer)
//   slot_valid        valid bit per slot
//   slot_tagindex     {tag,index} per slot
//   search_tagindex   address being looked up
//   fifo_advance      bump the FIFO pointer this cycle
//   hit / hit_slot    address found in a valid slot, and which one
//   has_free / free_slot  some slot is invalid, and the lowest such slot
//   fifo_ptr          current replacement pointer
// -----------------------------------------------------------------------------
module vc_alloc #(
    parameter int SIZE   = 4,
    parameter int TI_W   = 26,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   slot_valid,
    input  logic [TI_W-1:0]   slot_tagindex [SIZE],
    input  logic [TI_W-1:0]   search_tagindex,
    input  logic              fifo_advance,
    output logic              hit,
    output logic [SLOT_W-1:0] hit_slot,
    output logic              has_free,
    output logic [SLOT_W-1:0] free_slot,
    output logic [SLOT_W-1:0] fifo_ptr
);

    logic [SLOT_W-1:0] fifo_ptr_q;
    logic [SLOT_W-1:0] fifo_ptr_d;

    // Scan from the top down so the lowest-numbered match/free slot is the
    // one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_slot  = '0;
        has_free  = 1'b0;
        free_slot = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_tagindex[i] == search_tagindex)) begin
                hit      = 1'b1;
                hit_slot = SLOT_W'(i);
            end
            if (!slot_valid[i]) begin
                has_free  = 1'b1;
                free_slot = SLOT_W'(i);
            end
        end
    end

    // SIZE is a power of two, so natural wrap of the counter is modulo SIZE.
    always_comb begin
        fifo_ptr_d = fifo_ptr_q;
        if (fifo_advance) begin
            fifo_ptr_d = fifo_ptr_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_ptr_q <= '0;
        end else begin
            fifo_ptr_q <= fifo_ptr_d;
        end
    end

    assign fifo_ptr = fifo_ptr_q;

endmodule

// File: rtl/victim_cache_ctrl.sv
// -----------------------------------------------------------------------------
// victim_cache_ctrl
//   Sequencing controller between the L1 D-cache miss/refill FSM and a
//   fully-associative victim array (tag/valid/index LUTRAM + data RAMs).
//   Keeps a flop directory of every slot for single-cycle search.
//   PROBE: on a hit the line is read, returned to L1 and the slot freed.
//   INSERT: an evicted L1 line is stored; if the chosen slot holds a dirty
//   line from a different address it is read and handed to the writeback
//   buffer first.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op                   0 = PROBE, 1 = INSERT
//   req_tagindex             {tag,index} of the line
//   req_dirty, req_line      INSERT line dirty bit and data
//   resp_valid               one-cycle completion pulse (no backpressure)
//   resp_hit, resp_dirty     PROBE hit and dirty bit of the hit line
//   resp_line                hit line data (from the line buffer)
//   wb_valid/wb_ready        displaced dirty line handshake
//   wb_addr, wb_line         {tag,index} and data of the displaced line
//   vc_index                 array slot address (upper bits zero)
//   vc_we                    array write enable
//   vc_data_read_en          array data read enable
//   vc_tagvindex_wdata       {valid,tag,index} written to the LUTRAM
//   vc_data_wdata            array line write data
//   vc_data_rdata            array read data, one cycle after read enable
// -----------------------------------------------------------------------------
module victim_cache_ctrl
    import victim_cache_ctrl_pkg::*;
#(
    parameter int SIZE          = VC_SIZE,
    parameter int INDEX_WIDTH   = VC_INDEX_WIDTH,
    parameter int TAG_WIDTH     = VC_TAG_WIDTH,
    parameter int LINE_WORD_NUM = VC_LINE_WORD_NUM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_op,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]  req_tagindex,
    input  logic                              req_dirty,
    input  logic [LINE_WORD_NUM*32-1:0]       req_line,
    output logic                              resp_valid,
    output logic                              resp_hit,
    output logic                              resp_dirty,
    output logic [LINE_WORD_NUM*32-1:0]       resp_line,
    output logic                              wb_valid,
    input  logic                              wb_ready,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0]  wb_addr,
    output logic [LINE_WORD_NUM*32-1:0]       wb_line,
    output logic [INDEX_WIDTH-1:0]            vc_index,
    output logic                              vc_we,
    output logic                              vc_data_read_en,
    output logic [TAG_WIDTH+INDEX_WIDTH:0]    vc_tagvindex_wdata,
    output logic [LINE_WORD_NUM*32-1:0]       vc_data_wdata,
    input  logic [LINE_WORD_NUM*32-1:0]       vc_data_rdata
);

    localparam int TI_W   = TAG_WIDTH + INDEX_WIDTH;
    localparam int SLOT_W = $clog2(SIZE);

    vc_state_e         state_q, state_d;
    vc_dir_t           dir_q [SIZE];
    vc_dir_t           dir_d [SIZE];

    // Request buffer
    vc_op_e            req_op_q, req_op_d;
    logic [TI_W-1:0]   req_tagindex_q, req_tagindex_d;
    logic              req_dirty_q, req_dirty_d;
    line_t             req_line_q, req_line_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              hit_q, hit_d;

    // Line buffer and its capture strobe (array data lands one cycle after
    // the read enable).
    logic              rd_pending_q, rd_pending_d;
    line_t             line_buf_q, line_buf_d;

    // Allocator interface
    logic [SIZE-1:0]   slot_valid;
    logic [TI_W-1:0]   slot_tagindex [SIZE];
    logic              hit;
    logic [SLOT_W-1:0] hit_slot;
    logic              has_free;
    logic [SLOT_W-1:0] free_slot;
    logic [SLOT_W-1:0] fifo_ptr;
    logic              fifo_advance;
    logic [SLOT_W-1:0] victim_slot;
    logic              victim_dirty;

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            slot_valid[i]    = dir_q[i].valid;
            slot_tagindex[i] = dir_tagindex(dir_q[i]);
        end
    end

    vc_alloc #(
        .SIZE   (SIZE),
        .TI_W   (TI_W),
        .SLOT_W (SLOT_W)
    ) u_alloc (
        .clk             (clk),
        .rst             (rst),
        .slot_valid      (slot_valid),
        .slot_tagindex   (slot_tagindex),
        .search_tagindex (req_tagindex),
        .fifo_advance    (fifo_advance),
        .hit             (hit),
        .hit_slot        (hit_slot),
        .has_free        (has_free),
        .free_slot       (free_slot),
        .fifo_ptr        (fifo_ptr)
    );

    // Victim choice: reuse a matching slot, else the lowest free slot, else
    // the FIFO pointer. Only the FIFO case can displace a live line, so only
    // that case can need a writeback.
    always_comb begin
        if (hit) begin
            victim_slot = hit_slot;
        end else if (has_free) begin
            victim_slot = free_slot;
        end else begin
            victim_slot = fifo_ptr;
        end
        victim_dirty = !hit && !has_free && dir_q[fifo_ptr].dirty;
    end

    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        req_op_d       = req_op_q;
        req_tagindex_d = req_tagindex_q;
        req_dirty_d    = req_dirty_q;
        req_line_d     = req_line_q;
        slot_d         = slot_q;
        hit_d          = hit_q;
        rd_pending_d   = 1'b0;
        line_buf_d     = rd_pending_q ? line_t'(vc_data_rdata) : line_buf_q;
        fifo_advance   = 1'b0;

        req_ready          = 1'b0;
        resp_valid         = 1'b0;
        resp_hit           = 1'b0;
        resp_dirty         = 1'b0;
        wb_valid           = 1'b0;
        wb_addr            = '0;
        vc_index           = '0;
        vc_we              = 1'b0;
        vc_data_read_en    = 1'b0;
        vc_tagvindex_wdata = '0;
        vc_data_wdata      = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_op_d       = vc_op_e'(req_op);
                    req_tagindex_d = req_tagindex;
                    req_dirty_d    = req_dirty;
                    req_line_d     = line_t'(req_line);
                    hit_d          = hit;
                    slot_d         = victim_slot;
                    if (vc_op_e'(req_op) == VC_PROBE) begin
                        state_d = hit ? ST_P_RD : ST_P_RESP;
                    end else begin
                        fifo_advance = !hit && !has_free;
                        state_d      = victim_dirty ? ST_I_RD : ST_I_WR;
                    end
                end
            end

            ST_P_RD: begin
                vc_index        = INDEX_WIDTH'(slot_q);
                vc_data_read_en = 1'b1;
                rd_pending_d    = 1'b1;
                state_d         = ST_P_RESP;
            end

            ST_P_RESP: begin
                resp_valid = 1'b1;
                if (hit_q && (req_op_q == VC_PROBE)) begin
                    // Exclusive cache: the line moves back to L1, so the
                    // slot is invalidated in the same cycle it is returned.
                    resp_hit           = 1'b1;
                    resp_dirty         = dir_q[slot_q].dirty;
                    vc_we              = 1'b1;
                    vc_index           = INDEX_WIDTH'(slot_q);
                    vc_tagvindex_wdata = {1'b0, dir_tagindex(dir_q[slot_q])};
                    dir_d[slot_q].valid = 1'b0;
                    dir_d[slot_q].dirty = 1'b0;
                end
                state_d = ST_IDLE;
            end

            ST_I_RD: begin
                vc_index        = INDEX_WIDTH'(slot_q);
                vc_data_read_en = 1'b1;
                rd_pending_d    = 1'b1;
                state_d         = ST_I_WB;
            end

            ST_I_WB: begin
                // Directory still holds the displaced line until I_WR.
                wb_valid = 1'b1;
                wb_addr  = dir_tagindex(dir_q[slot_q]);
                if (wb_ready) begin
                    state_d = ST_I_WR;
                end
            end

            ST_I_WR: begin
                vc_we              = 1'b1;
                vc_index           = INDEX_WIDTH'(slot_q);
                vc_tagvindex_wdata = {1'b1, req_tagindex_q};
                vc_data_wdata      = req_line_q;
                dir_d[slot_q].valid = 1'b1;
                dir_d[slot_q].dirty = req_dirty_q;
                dir_d[slot_q].tag   = req_tagindex_q[TI_W-1:INDEX_WIDTH];
                dir_d[slot_q].index = req_tagindex_q[INDEX_WIDTH-1:0];
                resp_valid         = 1'b1;
                state_d            = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Both line outputs follow the buffer input so the line is visible in
    // the very cycle the array data arrives.
    assign resp_line = line_buf_d;
    assign wb_line   = line_buf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hit_q        <= 1'b0;
            slot_q       <= '0;
            rd_pending_q <= 1'b0;
            // Cleared so resp_line/wb_line read zero out of reset.
            line_buf_q   <= '0;
            for (int i = 0; i < SIZE; i++) begin
                dir_q[i].valid <= 1'b0;
                dir_q[i].dirty <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            hit_q        <= hit_d;
            slot_q       <= slot_d;
            rd_pending_q <= rd_pending_d;
            line_buf_q   <= line_buf_d;
            for (int i = 0; i < SIZE; i++) begin
                dir_q[i] <= dir_d[i];
            end
        end
    end

    // Request payload and directory tag fields carry no reset.
    always_ff @(posedge clk) begin
        req_op_q       <= req_op_d;
        req_tagindex_q <= req_tagindex_d;
        req_dirty_q    <= req_dirty_d;
        req_line_q     <= req_line_d;
    end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
module tb_victim_cache_ctrl;

    localparam int TIW = 26;
    localparam int LW  = 512;

    localparam logic [TIW-1:0] T0 = {20'h12345, 6'h07};
    localparam logic [TIW-1:0] TA = {20'hA0001, 6'h01};
    localparam logic [TIW-1:0] TB = {20'hB0002, 6'h02};
    localparam logic [TIW-1:0] TC = {20'hC0003, 6'h03};
    localparam logic [TIW-1:0] TD = {20'hD0004, 6'h04};
    localparam logic [TIW-1:0] TE = {20'hE0005, 6'h05};
    localparam logic [TIW-1:0] TF = {20'hF0006, 6'h06};

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid, req_ready, req_op, req_dirty;
    logic [TIW-1:0] req_tagindex;
    logic [LW-1:0]  req_line;
    logic           resp_valid, resp_hit, resp_dirty;
    logic [LW-1:0]  resp_line;
    logic           wb_valid, wb_ready;
    logic [TIW-1:0] wb_addr;
    logic [LW-1:0]  wb_line;
    logic [5:0]     vc_index;
    logic           vc_we, vc_data_read_en;
    logic [TIW:0]   vc_tagvindex_wdata;
    logic [LW-1:0]  vc_data_wdata;
    logic [LW-1:0]  vc_data_rdata = '0;

    logic [LW-1:0]  mem [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    victim_cache_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_tagindex       (req_tagindex),
        .req_dirty          (req_dirty),
        .req_line           (req_line),
        .resp_valid         (resp_valid),
        .resp_hit           (resp_hit),
        .resp_dirty         (resp_dirty),
        .resp_line          (resp_line),
        .wb_valid           (wb_valid),
        .wb_ready           (wb_ready),
        .wb_addr            (wb_addr),
        .wb_line            (wb_line),
        .vc_index           (vc_index),
        .vc_we              (vc_we),
        .vc_data_read_en    (vc_data_read_en),
        .vc_tagvindex_wdata (vc_tagvindex_wdata),
        .vc_data_wdata      (vc_data_wdata),
        .vc_data_rdata      (vc_data_rdata)
    );

    // Victim data array model: one-cycle read latency.
    always @(posedge clk) begin
        if (vc_we) mem[vc_index[1:0]] <= vc_data_wdata;
        if (vc_data_read_en) vc_data_rdata <= mem[vc_index[1:0]];
    end

    typedef struct {
        logic           rst_before;
        logic           op;
        logic [TIW-1:0] ti;
        logic           dirty;
        logic [7:0]     seed;
        int             stall;
        int             exp_lat;
        logic           exp_hit;
        logic           exp_rdirty;
        logic [7:0]     exp_rseed;
        logic           exp_wb;
        logic [TIW-1:0] exp_wb_addr;
        int             exp_we;
        int             exp_slot;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [LW-1:0] mk_line(input logic [7:0] seed);
        logic [LW-1:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = {seed, 24'(i)};
        return l;
    endfunction

    function automatic vec_t mkv(input logic rb, input logic op, input logic [TIW-1:0] ti,
                                 input logic d, input logic [7:0] seed, input int stall,
                                 input int lat, input logic hit, input logic rd,
                                 input logic [7:0] rseed, input logic wb,
                                 input logic [TIW-1:0] wba, input int we, input int slot);
        vec_t v;
        v.rst_before = rb;  v.op = op;       v.ti = ti;          v.dirty = d;
        v.seed = seed;      v.stall = stall; v.exp_lat = lat;    v.exp_hit = hit;
        v.exp_rdirty = rd;  v.exp_rseed = rseed; v.exp_wb = wb;  v.exp_wb_addr = wba;
        v.exp_we = we;      v.exp_slot = slot;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int             c;
        bit             done;
        int             lat;
        logic           r_hit, r_dirty;
        logic [LW-1:0]  r_line;
        int             we_cnt;
        int             we_slot;
        logic [TIW:0]   we_tv;
        logic [LW-1:0]  we_data;
        int             wb_cyc;
        logic [TIW-1:0] wb_a0;
        logic [LW-1:0]  wb_l0;
        bit             unstable;
        bit             both;

        if (v.rst_before) do_reset();
        @(negedge clk);
        chk($sformatf("v%0d req_ready", n), req_ready, 1);
        req_valid    = 1'b1;
        req_op       = v.op;
        req_tagindex = v.ti;
        req_dirty    = v.dirty;
        req_line     = mk_line(v.seed);
        @(posedge clk); #1;
        req_valid = 1'b0;

        c = 1; done = 0; lat = 0; r_hit = 0; r_dirty = 0; r_line = '0;
        we_cnt = 0; we_slot = -1; we_tv = '0; we_data = '0;
        wb_cyc = 0; wb_a0 = '0; wb_l0 = '0; unstable = 0; both = 0;
        while (!done && c <= 30) begin
            if (vc_we && vc_data_read_en) both = 1;
            if (vc_we) begin
                we_cnt++;
                we_slot = int'(vc_index);
                we_tv   = vc_tagvindex_wdata;
                we_data = vc_data_wdata;
            end
            if (wb_valid) begin
                if (wb_cyc == 0) begin
                    wb_a0 = wb_addr;
                    wb_l0 = wb_line;
                end else if (wb_addr !== wb_a0 || wb_line !== wb_l0) begin
                    unstable = 1;
                end
                wb_ready = (wb_cyc >= v.stall);
                wb_cyc++;
            end else begin
                wb_ready = 1'b0;
            end
            if (resp_valid) begin
                done    = 1;
                lat     = c;
                r_hit   = resp_hit;
                r_dirty = resp_dirty;
                r_line  = resp_line;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        wb_ready = 1'b0;

        chk($sformatf("v%0d resp_seen", n), done, 1);
        chk($sformatf("v%0d latency", n), lat, v.exp_lat);
        chk($sformatf("v%0d resp_hit", n), r_hit, v.exp_hit);
        if (v.exp_hit) begin
            chk($sformatf("v%0d resp_dirty", n), r_dirty, v.exp_rdirty);
            chk($sformatf("v%0d resp_line", n), r_line, mk_line(v.exp_rseed));
        end
        chk($sformatf("v%0d wb_seen", n), (wb_cyc > 0), v.exp_wb);
        if (v.exp_wb) begin
            chk($sformatf("v%0d wb_addr", n), wb_a0, v.exp_wb_addr);
            chk($sformatf("v%0d wb_line", n), wb_l0, mk_line(v.exp_rseed));
            chk($sformatf("v%0d wb_stable", n), unstable, 0);
            chk($sformatf("v%0d wb_cycles", n), wb_cyc, v.stall + 1);
        end
        chk($sformatf("v%0d we_count", n), we_cnt, v.exp_we);
        if (v.exp_we > 0) begin
            chk($sformatf("v%0d we_slot", n), we_slot, v.exp_slot);
            if (v.op) begin
                chk($sformatf("v%0d we_tagv", n), we_tv, {1'b1, v.ti});
                chk($sformatf("v%0d we_data", n), we_data, mk_line(v.seed));
            end else begin
                chk($sformatf("v%0d we_invalidate", n), we_tv[TIW], 0);
            end
        end
        chk($sformatf("v%0d we_and_rd", n), both, 0);

        @(posedge clk); #1;
        chk($sformatf("v%0d resp_pulse_end", n), resp_valid, 0);
    endtask

    initial begin
        int c;

        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_dirty = 1'b0;
        req_tagindex = '0; req_line = '0; wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", req_ready, 1);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst wb_valid", wb_valid, 0);
        chk("rst vc_we", vc_we, 0);
        chk("rst read_en", vc_data_read_en, 0);
        chk("rst vc_index", vc_index, 0);
        chk("rst tagv_wdata", vc_tagvindex_wdata, 0);
        chk("rst resp_line", resp_line, 0);
        chk("rst wb_addr", wb_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        //             rb  op  ti  d  seed stl lat hit rd rsd wb wba we slot
        vecs.push_back(mkv(0, 0, T0, 0, 0,  0, 1, 0, 0, 0,  0, 0,  0, 0));
        vecs.push_back(mkv(0, 1, T0, 0, 0,  0, 1, 0, 0, 0,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 0, T0, 0, 0,  0, 2, 1, 0, 0,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 0, T0, 0, 0,  0, 1, 0, 0, 0,  0, 0,  0, 0));
        vecs.push_back(mkv(0, 1, TA, 1, 1,  0, 1, 0, 0, 0,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 1, TB, 1, 2,  0, 1, 0, 0, 0,  0, 0,  1, 1));
        vecs.push_back(mkv(0, 1, TC, 1, 3,  0, 1, 0, 0, 0,  0, 0,  1, 2));
        vecs.push_back(mkv(0, 1, TD, 1, 4,  0, 1, 0, 0, 0,  0, 0,  1, 3));
        vecs.push_back(mkv(0, 1, TE, 0, 5,  3, 6, 0, 0, 1,  1, TA, 1, 0));
        vecs.push_back(mkv(0, 1, TF, 0, 11, 0, 3, 0, 0, 2,  1, TB, 1, 1));
        vecs.push_back(mkv(0, 0, TE, 0, 0,  0, 2, 1, 0, 5,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 0, TC, 0, 0,  0, 2, 1, 1, 3,  0, 0,  1, 2));
        vecs.push_back(mkv(1, 1, TA, 0, 6,  0, 1, 0, 0, 0,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 1, TB, 0, 7,  0, 1, 0, 0, 0,  0, 0,  1, 1));
        vecs.push_back(mkv(0, 1, TC, 0, 8,  0, 1, 0, 0, 0,  0, 0,  1, 2));
        vecs.push_back(mkv(0, 1, TD, 0, 9,  0, 1, 0, 0, 0,  0, 0,  1, 3));
        vecs.push_back(mkv(0, 1, TE, 0, 10, 0, 1, 0, 0, 0,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 0, TA, 0, 0,  0, 1, 0, 0, 0,  0, 0,  0, 0));
        vecs.push_back(mkv(0, 0, TE, 0, 0,  0, 2, 1, 0, 10, 0, 0,  1, 0));
        vecs.push_back(mkv(0, 1, TA, 1, 12, 0, 1, 0, 0, 0,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 1, TA, 0, 13, 0, 1, 0, 0, 0,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 0, TA, 0, 0,  0, 2, 1, 0, 13, 0, 0,  1, 0));
        vecs.push_back(mkv(1, 1, TA, 1, 1,  0, 1, 0, 0, 0,  0, 0,  1, 0));
        vecs.push_back(mkv(0, 1, TB, 1, 2,  0, 1, 0, 0, 0,  0, 0,  1, 1));
        vecs.push_back(mkv(0, 1, TC, 1, 3,  0, 1, 0, 0, 0,  0, 0,  1, 2));
        vecs.push_back(mkv(0, 1, TD, 1, 4,  0, 1, 0, 0, 0,  0, 0,  1, 3));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset while waiting in I_WB with wb_ready low.
        @(negedge clk);
        req_valid = 1'b1; req_op = 1'b1; req_tagindex = TE; req_dirty = 1'b0;
        req_line = mk_line(8'd20);
        @(posedge clk); #1;
        req_valid = 1'b0;
        c = 0;
        while (!wb_valid && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        chk("midrst wb_valid_reached", wb_valid, 1);
        chk("midrst wb_addr", wb_addr, TA);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("midrst wb_held", wb_valid, 1);
        chk("midrst wb_addr_held", wb_addr, TA);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst wb_dropped", wb_valid, 0);
        chk("midrst req_ready", req_ready, 1);
        chk("midrst no_resp", resp_valid, 0);
        chk("midrst no_we", vc_we, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst no_late_resp", resp_valid, 0);

        run_vec(mkv(0, 0, TA, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 100);
        run_vec(mkv(0, 0, TB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 101);
        run_vec(mkv(0, 0, TC, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 102);
        run_vec(mkv(0, 0, TD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 103);
        run_vec(mkv(0, 0, TE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/victim_cache_ctrl.md
Name: victim_cache_ctrl

Overview:
- Sequencing controller for the fully-associative victim cache array (tag/valid/index LUTRAM plus per-word data RAMs, SIZE slots).
- Sits between the L1 D-cache miss/refill FSM and the victim array. Keeps a flop copy of every slot's valid/tag/index/dirty for single-cycle associative search.
- Handles PROBE (hit: line moves back to L1, slot freed) and INSERT (evicted L1 line stored; a displaced dirty victim goes to the writeback buffer first).
- The victim array is used exclusively: a line is never in both L1 and the victim cache.

Parameters:
- SIZE, 4, victim slots (power of 2, ≥2)
- INDEX_WIDTH, 6, L1 set-index width
- TAG_WIDTH, 20, L1 tag width
- LINE_WORD_NUM, 16, 32-bit words per line

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  accept; high only in IDLE
- req_op  in  1  0=PROBE, 1=INSERT
- req_tagindex  in  TAG_WIDTH+INDEX_WIDTH  {tag,index} of line
- req_dirty  in  1  INSERT line dirty
- req_line  in  LINE_WORD_NUM*32  INSERT line data
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  PROBE hit
- resp_dirty  out  1  dirty bit of hit line
- resp_line  out  LINE_WORD_NUM*32  hit line data
- wb_valid  out  1  displaced dirty line valid
- wb_ready  in  1  writeback buffer accepts
- wb_addr  out  TAG_WIDTH+INDEX_WIDTH  {tag,index} of displaced line
- wb_line  out  LINE_WORD_NUM*32  displaced line data
- vc_index  out  INDEX_WIDTH  array slot address; upper bits 0
- vc_we  out  1  array write enable
- vc_data_read_en  out  1  array data read enable
- vc_tagvindex_wdata  out  1+TAG_WIDTH+INDEX_WIDTH  {valid,tag,index}
- vc_data_wdata  out  LINE_WORD_NUM*32  array write data
- vc_data_rdata  in  LINE_WORD_NUM*32  array read data, 1 cycle after read_en

Behaviour:
- Reset:
  - All directory valid/dirty bits 0; FIFO pointer 0; state IDLE.
  - All outputs 0 except req_ready=1.
  - A reset mid-operation aborts it: no resp_valid, wb_valid dropped, line buffer contents irrelevant.
- Accept: in IDLE, req_valid&&req_ready. Latch op, tagindex, dirty and line into a request buffer. Search the directory combinationally in the accept cycle; latch hit and slot.
- Data read: array data is valid the cycle after vc_data_read_en. The controller copies it into a line buffer in that cycle. resp_line and wb_line are always driven from that buffer.
- FSM states: IDLE, P_RD, P_RESP, I_RD, I_WB, I_WR.
- PROBE miss: IDLE→P_RESP. resp_valid(hit=0) 1 cycle after accept, then IDLE.
- PROBE hit at slot s:
  - P_RD: read_en=1, vc_index=s.
  - P_RESP: capture line; resp_valid=1, resp_hit=1, resp_dirty=dir[s].
  - Also in P_RESP: vc_we=1 with valid=0 to slot s; clear dir[s].
  - Then IDLE. resp_valid is 2 cycles after accept.
- INSERT, victim slot selection:
  - If the tag already matches a valid slot: reuse that slot, no writeback.
  - Else the lowest-numbered invalid slot.
  - Else slot = FIFO pointer; the pointer increments modulo SIZE only in this case.
- INSERT, clean path: if the chosen slot is invalid or clean, go IDLE→I_WR.
- INSERT, dirty path: if the chosen slot is valid and dirty:
  - I_RD: read_en=1.
  - I_WB: capture line; wb_valid=1 and wb_addr=dir tag/index, held until wb_ready.
  - wb_ready may already be high in the first I_WB cycle, giving a 1-cycle handshake.
- I_WR:
  - vc_we=1, vc_tagvindex_wdata={1,req tagindex}, vc_data_wdata=req_line.
  - Update the directory: dirty=req_dirty.
  - resp_valid=1, resp_hit=0; then IDLE.
- Latency: INSERT clean 1 cycle; dirty 3 + wb stall cycles.
- resp_valid has no backpressure; the L1 FSM always samples it.
- vc_we and vc_data_read_en are never high in the same cycle.

Decomposition:
- Shared cache package:
  - vc_op_e (PROBE/INSERT)
  - vc_dir_t {valid,dirty,tag,index} packed struct
  - line_t as [LINE_WORD_NUM-1:0][31:0]
- Sub-module vc_alloc: combinational hit search, first-invalid priority encoder, FIFO pointer register and increment.

Test Plan:
- Reset, then PROBE 0x12345_07 → resp_valid 1 cycle after accept, hit=0; vc_we never asserted.
- INSERT 0x12345_07, clean, line words 0..15=i → vc_we on slot 0 the cycle after accept, resp hit=0. PROBE same → resp 2 cycles later, hit=1, dirty=0, words=i. A second PROBE misses.
- Fill 4 slots via dirty INSERTs A–D, then INSERT E → slot 0 read, wb_valid with wb_addr=A. Hold wb_ready=0 for 3 cycles: outputs stable. Then E written to slot 0; FIFO pointer=1.
- Fill with clean A–D, then INSERT E → no wb_valid; resp 1 cycle after accept; E replaces slot 0.
- INSERT A (dirty), then INSERT A again (clean) → same slot reused, no writeback, dirty=0. PROBE A → resp_dirty=0.
- Assert rst in I_WB with wb_ready=0 → next cycle wb_valid=0, req_ready=1, all directory entries invalid, PROBE misses.
